// File: rtl/d8_mem_data_arbiter_if.sv
// d8_mem_data_arbiter_if: core, debug and data-RAM bus bundle for the data memory arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters'/RAM view.
interface d8_mem_data_arbiter_if #(
  parameter int AW = 8
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_adr;
  logic [7:0]    c_dw;
  logic [7:0]    c_dr;
  logic          c_ack;
  logic          c_err;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_adr;
  logic [7:0]    d_dw;
  logic [7:0]    d_dr;
  logic          d_ack;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_adr;
  logic [7:0]    m_dw;
  logic [7:0]    m_dr;
  logic          busy;
  modport slave (
    input  c_req, c_we, c_adr, c_dw, d_req, d_we, d_adr, d_dw, m_dr,
    output c_dr, c_ack, c_err, d_dr, d_ack, m_en, m_we, m_adr, m_dw, busy
  );
  modport master (
    output c_req, c_we, c_adr, c_dw, d_req, d_we, d_adr, d_dw, m_dr,
    input  c_dr, c_ack, c_err, d_dr, d_ack, m_en, m_we, m_adr, m_dw, busy
  );
endinterface

// File: rtl/d8_mem_data_arbiter.sv
// d8_mem_data_arbiter: round-robin sharing of the single-port data RAM between core and debug ports.
// Define D8_MEM_DATA_WPROT_EN to turn core writes at or above WP_BASE into reads flagged by c_err.
module d8_mem_data_arbiter #(
  parameter int            AW      = 8,
  parameter logic [AW-1:0] WP_BASE = AW'(8'hF0)
) (
  input logic                  sys_clk,
  input logic                  sys_rst,
  d8_mem_data_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEM, RESP, ACK} state_t;
  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic          sel_q, sel_d;
  logic          err_q, err_d;
  logic          m_en_q, m_en_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_adr_q, m_adr_d;
  logic [7:0]    m_dw_q, m_dw_d;
  logic [7:0]    c_dr_q, c_dr_d;
  logic [7:0]    d_dr_q, d_dr_d;
  logic          c_ack_q, c_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          c_err_q, c_err_d;
  logic          win;
  logic          prot;
  // rr_q=1 means debug was granted last, so the core takes the next tie
  assign win = bus.d_req & (~bus.c_req | ~rr_q);
`ifdef D8_MEM_DATA_WPROT_EN
  assign prot = ~win & bus.c_we & (bus.c_adr >= WP_BASE);
`else
  logic unused_wp;
  assign prot      = 1'b0;
  assign unused_wp = ^WP_BASE;
`endif
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    err_d   = err_q;
    m_en_d  = 1'b0;
    m_we_d  = 1'b0;
    m_adr_d = m_adr_q;
    m_dw_d  = m_dw_q;
    c_dr_d  = c_dr_q;
    d_dr_d  = d_dr_q;
    c_ack_d = 1'b0;
    d_ack_d = 1'b0;
    c_err_d = 1'b0;
    unique case (state_q)
      IDLE: if (bus.c_req | bus.d_req) begin
        state_d = MEM;
        sel_d   = win;
        rr_d    = win;
        err_d   = prot;
        m_en_d  = 1'b1;
        m_we_d  = (win ? bus.d_we : bus.c_we) & ~prot;
        m_adr_d = win ? bus.d_adr : bus.c_adr;
        m_dw_d  = win ? bus.d_dw : bus.c_dw;
      end
      MEM:  state_d = RESP;
      RESP: begin
        state_d = ACK;
        c_dr_d  = sel_q ? c_dr_q : bus.m_dr;
        d_dr_d  = sel_q ? bus.m_dr : d_dr_q;
        c_ack_d = ~sel_q;
        d_ack_d = sel_q;
        c_err_d = err_q & ~sel_q;
      end
      ACK:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b1;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      m_en_q  <= 1'b0;
      m_we_q  <= 1'b0;
      m_adr_q <= '0;
      m_dw_q  <= '0;
      c_dr_q  <= '0;
      d_dr_q  <= '0;
      c_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      c_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      m_en_q  <= m_en_d;
      m_we_q  <= m_we_d;
      m_adr_q <= m_adr_d;
      m_dw_q  <= m_dw_d;
      c_dr_q  <= c_dr_d;
      d_dr_q  <= d_dr_d;
      c_ack_q <= c_ack_d;
      d_ack_q <= d_ack_d;
      c_err_q <= c_err_d;
    end
  end
  assign bus.m_en  = m_en_q;
  assign bus.m_we  = m_we_q;
  assign bus.m_adr = m_adr_q;
  assign bus.m_dw  = m_dw_q;
  assign bus.c_dr  = c_dr_q;
  assign bus.d_dr  = d_dr_q;
  assign bus.c_ack = c_ack_q;
  assign bus.d_ack = d_ack_q;
  assign bus.c_err = c_err_q;
  assign bus.busy  = state_q != IDLE;
endmodule

// File: tb/tb_d8_mem_data_arbiter.sv
// tb_d8_mem_data_arbiter: directed and random accesses checked against a transaction-level model
// (round-robin order, 4-cycle slots, reference memory image, optional write protection).
module tb_d8_mem_data_arbiter;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  d8_mem_data_arbiter_if #(.AW(8)) bus ();
  d8_mem_data_arbiter #(.AW(8), .WP_BASE(8'hF0)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );
  always #5 sys_clk = ~sys_clk;
`ifdef D8_MEM_DATA_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif
  logic [7:0] ram [256] = '{default: 8'h00};
  logic [7:0] ram_q = 8'h00;
  always @(posedge sys_clk)
    if (bus.m_en) begin
      if (bus.m_we) ram[bus.m_adr] <= bus.m_dw;
      ram_q <= ram[bus.m_adr];
    end
  assign bus.m_dr = ram_q;
  logic [7:0] ref_mem [256];
  int n_run = 0;
  int n_fail = 0;
  bit rr = 1'b1;
  bit in_ack = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      chk("idle_busy", bus.busy, 0);
      chk("idle_m_en", bus.m_en, 0);
    end
    in_ack = 1'b0;
  endtask
  task automatic do_reset();
    sys_rst = 1'b1;
    bus.c_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge sys_clk);
    chk("rst_busy", bus.busy, 0);
    sys_rst = 1'b0;
    rr = 1'b1;
    in_ack = 1'b0;
  endtask
  // Presents one request per enabled port; each grant occupies a 4-cycle slot in round-robin order.
  task automatic access(input bit cv, input bit cw, input logic [7:0] ca, input logic [7:0] cd,
                        input bit dv, input bit dw, input logic [7:0] da, input logic [7:0] dd);
    bit ord [2];
    int n, lead, eff, s, o;
    bit p, we, pr;
    logic [7:0] a, wd, rd;
    n = int'(cv) + int'(dv);
    lead = int'(in_ack);
    ord[0] = (cv && dv) ? ~rr : dv;
    ord[1] = ~ord[0];
    rd = 8'h00;
    bus.c_req = cv; bus.c_we = cw; bus.c_adr = ca; bus.c_dw = cd;
    bus.d_req = dv; bus.d_we = dw; bus.d_adr = da; bus.d_dw = dd;
    for (int k = 1; k <= lead + 4 * n - 1; k++) begin
      @(negedge sys_clk);
      eff = k - lead;
      if (eff <= 0) begin
        chk("pre_busy", bus.busy, 0);
        chk("pre_m_en", bus.m_en, 0);
      end else begin
        s = (eff - 1) / 4;
        o = (eff - 1) % 4;
        p = ord[s];
        we = p ? dw : cw;
        a = p ? da : ca;
        wd = p ? dd : cd;
        pr = WPROT && !p && we && (a >= 8'hF0);
        chk("m_en", bus.m_en, o == 0);
        chk("busy", bus.busy, o != 3);
        chk("c_ack", bus.c_ack, o == 2 && !p);
        chk("d_ack", bus.d_ack, o == 2 && p);
        chk("c_err", bus.c_err, o == 2 && pr);
        if (o == 0) begin
          chk("m_we", bus.m_we, we && !pr);
          chk("m_adr", bus.m_adr, a);
          if (we && !pr) chk("m_dw", bus.m_dw, wd);
          rd = ref_mem[a];
          if (we && !pr) ref_mem[a] = wd;
          rr = p;
          if (p) begin
            bus.d_adr = 8'($urandom); bus.d_dw = 8'($urandom); bus.d_we = 1'($urandom);
          end else begin
            bus.c_adr = 8'($urandom); bus.c_dw = 8'($urandom); bus.c_we = 1'($urandom);
          end
        end
        if (o == 2) begin
          if (!we) chk(p ? "d_dr" : "c_dr", p ? bus.d_dr : bus.c_dr, rd);
          if (p) bus.d_req = 1'b0;
          else bus.c_req = 1'b0;
        end
      end
    end
    in_ack = 1'b1;
  endtask
  initial begin
    bit cv, dv, cw, dw;
    logic [7:0] ca, cd, da, dd;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_adr = 8'h10; bus.c_dw = 8'h11;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_adr = 8'h20; bus.d_dw = 8'h22;
    sys_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge sys_clk);
      chk("rst_m_en", bus.m_en, 0);
      chk("rst_m_we", bus.m_we, 0);
      chk("rst_m_adr", bus.m_adr, 0);
      chk("rst_m_dw", bus.m_dw, 0);
      chk("rst_c_dr", bus.c_dr, 0);
      chk("rst_d_dr", bus.d_dr, 0);
      chk("rst_c_ack", bus.c_ack, 0);
      chk("rst_d_ack", bus.d_ack, 0);
      chk("rst_c_err", bus.c_err, 0);
      chk("rst_busy", bus.busy, 0);
    end
    bus.c_req = 1'b0;
    bus.d_req = 1'b0;
    sys_rst = 1'b0;
    rr = 1'b1;
    idle(1);
    access(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00);
    access(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(1);
    do_reset();
    access(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b1, 8'h20, 8'h77);
    access(1'b1, 1'b1, 8'h21, 8'h5A, 1'b1, 1'b0, 8'h20, 8'h00);
    access(1'b1, 1'b0, 8'h21, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    idle(1);
    access(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h40, 8'h01);
    access(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h41, 8'h02);
    access(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h42, 8'h03);
    idle(1);
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_adr = 8'h10;
    @(negedge sys_clk);
    chk("mid_m_en", bus.m_en, 1);
    @(negedge sys_clk);
    chk("mid_resp_busy", bus.busy, 1);
    sys_rst = 1'b1;
    bus.c_req = 1'b0;
    @(negedge sys_clk);
    chk("mid_c_ack", bus.c_ack, 0);
    chk("mid_busy", bus.busy, 0);
    sys_rst = 1'b0;
    rr = 1'b1;
    in_ack = 1'b0;
    access(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(1);
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_adr = 8'h33; bus.c_dw = 8'hC3;
    @(negedge sys_clk);
    chk("wrst_m_en", bus.m_en, 1);
    chk("wrst_m_we", bus.m_we, 1);
    sys_rst = 1'b1;
    bus.c_req = 1'b0;
    ref_mem[8'h33] = 8'hC3;
    @(negedge sys_clk);
    chk("wrst_busy", bus.busy, 0);
    chk("wrst_c_ack", bus.c_ack, 0);
    sys_rst = 1'b0;
    rr = 1'b1;
    in_ack = 1'b0;
    access(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h33, 8'h00);
    access(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hF4, 8'h3C);
    access(1'b1, 1'b1, 8'hF4, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00);
    access(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hF4, 8'h00);
    access(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hF4, 8'h55);
    access(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hF4, 8'h00);
    repeat (120) begin
      cv = 1'($urandom);
      dv = 1'($urandom);
      if (!cv && !dv) cv = 1'b1;
      cw = 1'($urandom);
      dw = 1'($urandom);
      ca = 8'($urandom_range(0, 15)) | (($urandom % 2) != 0 ? 8'hF0 : 8'h00);
      da = 8'($urandom_range(0, 15)) | (($urandom % 2) != 0 ? 8'hF0 : 8'h00);
      cd = 8'($urandom);
      dd = 8'($urandom);
      if ($urandom % 3 == 0) idle(1 + int'($urandom % 2));
      access(cv, cw, ca, cd, dv, dw, da, dd);
    end
    idle(1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
